// File: rtl/fifo_push_arb_pkg.sv
// Shared types and helpers for the fifo_push_arb block: FSM states, pointer width
// and a one-hot to index conversion used by the round-robin picker.
package fifo_push_arb_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int MAX_REQ = 16;

   function automatic int rr_ptr_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // OR of set-bit positions; exact for a one-hot (or all-zero) vector.
   function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/fifo_push_arb_if.sv
// Producer/FIFO side bundle of fifo_push_arb. Optional urgent vector exists only
// when FIFO_PUSH_ARB_URGENT_EN is defined.
interface fifo_push_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2
);
   // Handshake: req[i] is a level; the arbiter accepts a word with a one-cycle
   // grant[i] pulse, and that same cycle carries fifo_push with the word. There is
   // no ready from the FIFO: the credit counter (level) guarantees room, and each
   // pop_done pulse returns one credit.
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            grant;
   logic                          fifo_push;
   logic [DATA_WIDTH-1:0]         fifo_data;
   logic                          fifo_full;
   logic                          pop_done;
   logic                          flush_req;
   logic                          flush_done;
   logic [ADDR_WIDTH:0]           level;
   logic                          err;
`ifdef FIFO_PUSH_ARB_URGENT_EN
   logic [NUM_REQ-1:0]            urgent;
`endif

   modport slave (
      input  req, req_data, fifo_full, pop_done, flush_req,
`ifdef FIFO_PUSH_ARB_URGENT_EN
      input  urgent,
`endif
      output grant, fifo_push, fifo_data, flush_done, level, err
   );

   modport master (
      output req, req_data, fifo_full, pop_done, flush_req,
`ifdef FIFO_PUSH_ARB_URGENT_EN
      output urgent,
`endif
      input  grant, fifo_push, fifo_data, flush_done, level, err
   );

endinterface

// File: rtl/fifo_push_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i searching upward
// from rr_ptr_i+1, wrapping modulo NUM_REQ.
module fifo_push_arb_rr_pick
   import fifo_push_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = rr_ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible_i,
   input  logic [PTR_W-1:0]   rr_ptr_i,
   output logic               valid_o,
   output logic [PTR_W-1:0]   idx_o,
   output logic [NUM_REQ-1:0] onehot_o
);

   logic [NUM_REQ-1:0] pick;
   logic               found;
   int                 c;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = (int'(rr_ptr_i) + k) % NUM_REQ;
         if (!found && eligible_i[c]) begin
            pick[c] = 1'b1;
            found   = 1'b1;
         end
      end
   end

   assign valid_o  = found;
   assign onehot_o = pick;
   assign idx_o    = PTR_W'(onehot_to_idx(MAX_REQ'(pick)));

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter sharing one FIFO push port, with occupancy credit counter
// and drain/flush FSM. Optional urgent priority: FIFO_PUSH_ARB_URGENT_EN.
module fifo_push_arb
   import fifo_push_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int FIFO_DEPTH = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_push_arb_if.slave        bus,
   output state_e                dbg_state_o
);

   localparam int PTR_W = rr_ptr_width(NUM_REQ);
   localparam int CW    = ADDR_WIDTH + 1;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [NUM_REQ-1:0]    grant_q, grant_d;
   logic                  push_q, push_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  err_q, err_d;

   logic [NUM_REQ-1:0]    eligible, pick_vec, pick_oh;
   logic [PTR_W-1:0]      pick_idx;
   logic                  pick_valid, issue, pop_dec;

   // Last cycle's winner is masked so a held req cannot push the same word twice.
   assign eligible = bus.req & ~grant_q;

`ifdef FIFO_PUSH_ARB_URGENT_EN
   logic [NUM_REQ-1:0] urg_elig;
   assign urg_elig = eligible & bus.urgent;
   assign pick_vec = (|urg_elig) ? urg_elig : eligible;
`else
   assign pick_vec = eligible;
`endif

   fifo_push_arb_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .eligible_i (pick_vec),
      .rr_ptr_i   (rr_ptr_q),
      .valid_o    (pick_valid),
      .idx_o      (pick_idx),
      .onehot_o   (pick_oh)
   );

   // Same-cycle pop_done is not credited: the decision uses count_q only.
   assign issue   = (state_q == RUN) && !bus.flush_req && pick_valid &&
                    (count_q < CW'(FIFO_DEPTH)) && !bus.fifo_full;
   assign pop_dec = bus.pop_done && (count_q != '0);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = '0;
      push_d   = 1'b0;
      data_d   = data_q;
      count_d  = count_q + CW'(issue) - CW'(pop_dec);
      err_d    = err_q | (bus.pop_done && (count_q == '0));

      if (issue) begin
         grant_d  = pick_oh;
         push_d   = 1'b1;
         data_d   = bus.req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
         rr_ptr_d = pick_idx;
      end

      case (state_q)
         RUN:   if (bus.flush_req) state_d = DRAIN;
         DRAIN: begin
            if (!bus.flush_req)                       state_d = RUN;
            else if ((count_q == '0) && !push_q)      state_d = DONE;
         end
         DONE:  if (!bus.flush_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         rr_ptr_q <= PTR_W'(NUM_REQ - 1);
         count_q  <= '0;
         grant_q  <= '0;
         push_q   <= 1'b0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         count_q  <= count_d;
         grant_q  <= grant_d;
         push_q   <= push_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   assign bus.grant      = grant_q;
   assign bus.fifo_push  = push_q;
   assign bus.fifo_data  = data_q;
   assign bus.level      = count_q;
   assign bus.err        = err_q;
   assign bus.flush_done = (state_q == DONE);
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed bench for fifo_push_arb: arbitration order, credit limit, single
// requester pacing, pop/issue overlap, flush sequence, error and reset.
module tb_fifo_push_arb;
   import fifo_push_arb_pkg::*;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int AW = 2;

   logic   clk;
   logic   reset;
   state_e dbg_state;
   int     total;
   int     bad;

   fifo_push_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_push_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      total         = 0;
      bad           = 0;
      reset         = 1'b1;
      bus.req       = '0;
      bus.fifo_full = 1'b0;
      bus.pop_done  = 1'b0;
      bus.flush_req = 1'b0;
`ifdef FIFO_PUSH_ARB_URGENT_EN
      bus.urgent    = '0;
`endif
      for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = 8'hA0 + 8'(i);

      step();
      step();
      check("rst_grant", 32'(bus.grant), 32'h0);
      check("rst_push", 32'(bus.fifo_push), 32'h0);
      check("rst_level", 32'(bus.level), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_fdone", 32'(bus.flush_done), 32'h0);
      reset = 1'b0;

      // All four held: grants 0,1,2,3 back to back, then credit runs out.
      bus.req = 4'b1111;
      for (int i = 0; i < NR; i++) begin
         step();
         check($sformatf("rr_grant%0d", i), 32'(bus.grant), 32'(4'b0001 << i));
         check($sformatf("rr_push%0d", i), 32'(bus.fifo_push), 32'h1);
         check($sformatf("rr_data%0d", i), 32'(bus.fifo_data), 32'hA0 + i);
         check($sformatf("rr_level%0d", i), 32'(bus.level), 32'(i + 1));
      end
      step();
      check("full_nogrant", 32'(bus.grant), 32'h0);
      check("full_nopush", 32'(bus.fifo_push), 32'h0);
      check("full_level", 32'(bus.level), 32'h4);

      // Credit full: req2 waits until one pop returns a credit.
      bus.req = 4'b0100;
      step();
      check("cred_wait", 32'(bus.grant), 32'h0);
      bus.pop_done = 1'b1;
      step();
      check("cred_pop_grant", 32'(bus.grant), 32'h0);
      check("cred_pop_level", 32'(bus.level), 32'h3);
      bus.pop_done = 1'b0;
      step();
      check("cred_grant2", 32'(bus.grant), 32'h4);
      check("cred_data2", 32'(bus.fifo_data), 32'hA2);
      check("cred_level4", 32'(bus.level), 32'h4);
      bus.req = '0;

      // Pop down to 2, then simultaneous pop and issue keeps level at 2.
      bus.pop_done = 1'b1;
      step();
      step();
      check("pop_to2", 32'(bus.level), 32'h2);
      bus.req = 4'b0010;
      step();
      check("sim_grant", 32'(bus.grant), 32'h2);
      check("sim_level", 32'(bus.level), 32'h2);
      bus.req      = '0;
      bus.pop_done = 1'b0;
      step();
      check("idle_grant", 32'(bus.grant), 32'h0);
      bus.pop_done = 1'b1;
      step();
      step();
      bus.pop_done = 1'b0;
      check("empty_level", 32'(bus.level), 32'h0);

      // Single requester held: grant every other cycle.
      bus.req = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("single_grant%0d", i), 32'(bus.grant), (i % 2 == 0) ? 32'h2 : 32'h0);
      end
      check("single_level", 32'(bus.level), 32'h3);

      // Flush with requests pending.
      bus.req       = 4'b1111;
      bus.flush_req = 1'b1;
      step();
      check("fl_nogrant", 32'(bus.grant), 32'h0);
      check("fl_state", 32'(dbg_state), 32'(DRAIN));
      check("fl_level3", 32'(bus.level), 32'h3);
      bus.pop_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("fl_drain_grant%0d", i), 32'(bus.grant), 32'h0);
      end
      bus.pop_done = 1'b0;
      check("fl_level0", 32'(bus.level), 32'h0);
      check("fl_done_early", 32'(bus.flush_done), 32'h0);
      step();
      check("fl_done", 32'(bus.flush_done), 32'h1);
      step();
      check("fl_done_hold", 32'(bus.flush_done), 32'h1);
      check("fl_done_nogrant", 32'(bus.grant), 32'h0);
      bus.flush_req = 1'b0;
      step();
      check("fl_release", 32'(bus.flush_done), 32'h0);
      check("fl_release_nogrant", 32'(bus.grant), 32'h0);
      step();
      check("fl_resume_grant", 32'(bus.grant), 32'h4);
      bus.req = '0;

      // Flush dropped mid-drain returns to RUN without DONE.
      bus.flush_req = 1'b1;
      step();
      check("abort_drain", 32'(dbg_state), 32'(DRAIN));
      bus.flush_req = 1'b0;
      step();
      check("abort_run", 32'(dbg_state), 32'(RUN));
      check("abort_fdone", 32'(bus.flush_done), 32'h0);

      // Underflow error.
      bus.pop_done = 1'b1;
      step();
      check("err_pre", 32'(bus.err), 32'h0);
      step();
      check("err_set", 32'(bus.err), 32'h1);
      check("err_level", 32'(bus.level), 32'h0);
      bus.pop_done = 1'b0;
      step();
      check("err_sticky", 32'(bus.err), 32'h1);

      // fifo_full blocks issue even with credit available.
      bus.fifo_full = 1'b1;
      bus.req       = 4'b0001;
      step();
      check("ffull_nogrant", 32'(bus.grant), 32'h0);
      bus.fifo_full = 1'b0;

      // Reset mid-grant.
      bus.req = 4'b1111;
      step();
      check("mid_push", 32'(bus.fifo_push), 32'h1);
      reset = 1'b1;
      step();
      check("mid_rst_push", 32'(bus.fifo_push), 32'h0);
      check("mid_rst_level", 32'(bus.level), 32'h0);
      check("mid_rst_err", 32'(bus.err), 32'h0);
      reset   = 1'b0;
      bus.req = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
